xif_result_buffer: RTL and testbench

- Buffers coprocessor results between the custom coprocessor (upstream) and the cv32e40x XIF result interface (downstream).
- Holds each result until the core has committed or killed the matching instruction id.
- Committed results are presented in order. Killed results are dropped silently.
- Commit may arrive before or after the matching result is buffered.

---
 rtl/xif_rbuf_pkg.sv | 27 ++
 rtl/xif_rbuf_fifo.sv | 53 +++++
 rtl/xif_result_buffer.sv | 125 ++++++++++++
 tb/tb_xif_result_buffer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xif_rbuf_pkg.sv
// Shared types for the XIF result buffer: FIFO entry, commit status and head decode.
package xif_rbuf_pkg;

  localparam int unsigned XIdWidth  = 4;
  localparam int unsigned XRfwWidth = 32;

  typedef struct packed {
    logic [XIdWidth-1:0]  id;
    logic [4:0]           rd;
    logic [XRfwWidth-1:0] data;
    logic                 we;
    logic                 exc;
  } rbuf_entry_t;

  typedef struct packed {
    logic seen;
    logic kill;
  } commit_stat_t;

  typedef enum logic [1:0] {
    HeadEmpty,
    HeadWait,
    HeadPresent,
    HeadDrop
  } head_state_e;

endpackage

// File: rtl/xif_rbuf_fifo.sv
// Circular FIFO of result entries; pointers carry an extra wrap bit so full and
// empty are distinguishable without a separate counter.
module xif_rbuf_fifo
  import xif_rbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IdxW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  rbuf_entry_t   wdata_i,
  input  logic          pop_i,
  output rbuf_entry_t   rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [IdxW:0] count_o
);

  logic [IdxW:0] wptr_q, wptr_d;
  logic [IdxW:0] rptr_q, rptr_d;
  rbuf_entry_t   mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[IdxW] != rptr_q[IdxW]) &&
                   (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[IdxW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push) mem_q[wptr_q[IdxW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/xif_result_buffer.sv
// Holds coprocessor results until the core commits or kills their id; committed
// results leave in order on the XIF result interface, killed ones are dropped.
module xif_result_buffer
  import xif_rbuf_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned X_ID_WIDTH  = XIdWidth,
  parameter int unsigned X_RFW_WIDTH = XRfwWidth
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [X_ID_WIDTH-1:0]      in_id_i,
  input  logic [4:0]                 in_rd_i,
  input  logic [X_RFW_WIDTH-1:0]     in_data_i,
  input  logic                       in_we_i,
  input  logic                       in_exc_i,
  input  logic                       commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]      commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [X_ID_WIDTH-1:0]      result_id_o,
  output logic [4:0]                 result_rd_o,
  output logic [X_RFW_WIDTH-1:0]     result_data_o,
  output logic                       result_we_o,
  output logic                       result_exc_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       protocol_err_o
);

  localparam int unsigned NumIds = 2 ** X_ID_WIDTH;

  rbuf_entry_t                wr_entry, head;
  logic                       full, empty, push, pop;
  commit_stat_t [NumIds-1:0]  tbl_q, tbl_d;
  logic [NumIds-1:0]          buffered_q, buffered_d;
  logic                       err_q, err_d;
  commit_stat_t               head_stat;
  head_state_e                head_state;

  assign wr_entry = '{id: in_id_i, rd: in_rd_i, data: in_data_i, we: in_we_i, exc: in_exc_i};

  // Held low while reset is asserted so nothing is accepted into a clearing buffer.
  assign in_ready_o = rst_ni && !full;
  assign push       = in_valid_i && in_ready_o;

  xif_rbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

  assign head_stat = tbl_q[head.id];

  always_comb begin
    head_state = HeadEmpty;
    if (!empty) begin
      if (!head_stat.seen)     head_state = HeadWait;
      else if (head_stat.kill) head_state = HeadDrop;
      else                     head_state = HeadPresent;
    end
  end

  assign pop = (head_state == HeadDrop) || ((head_state == HeadPresent) && result_ready_i);

  always_comb begin
    result_valid_o = (head_state == HeadPresent);
    result_id_o    = '0;
    result_rd_o    = '0;
    result_data_o  = '0;
    result_we_o    = 1'b0;
    result_exc_o   = 1'b0;
    if (result_valid_o) begin
      result_id_o   = head.id;
      result_rd_o   = head.rd;
      result_data_o = head.data;
      result_we_o   = head.we;
      result_exc_o  = head.exc;
    end
  end

  // Pop clears first; a commit to the popping id sees seen=1 and only flags an error.
  always_comb begin
    tbl_d      = tbl_q;
    buffered_d = buffered_q;
    err_d      = err_q;
    if (pop) begin
      tbl_d[head.id]      = '0;
      buffered_d[head.id] = 1'b0;
    end
    if (commit_valid_i) begin
      if (tbl_q[commit_id_i].seen) err_d = 1'b1;
      else tbl_d[commit_id_i] = '{seen: 1'b1, kill: commit_kill_i};
    end
    if (push) begin
      if (buffered_d[in_id_i]) err_d = 1'b1;
      buffered_d[in_id_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl_q      <= '0;
      buffered_q <= '0;
      err_q      <= 1'b0;
    end else begin
      tbl_q      <= tbl_d;
      buffered_q <= buffered_d;
      err_q      <= err_d;
    end
  end

  assign protocol_err_o = err_q;

endmodule

// File: tb/tb_xif_result_buffer.sv
// Randomised and directed bench for xif_result_buffer against a queue-based model.
module tb_xif_result_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NIDS  = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i, in_ready_o;
  logic [3:0]  in_id_i;
  logic [4:0]  in_rd_i;
  logic [31:0] in_data_i;
  logic        in_we_i, in_exc_i;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        result_valid_o, result_ready_i;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic [31:0] result_data_o;
  logic        result_we_o, result_exc_o;
  logic [2:0]  count_o;
  logic        protocol_err_o;

  always #5 clk_i = ~clk_i;

  xif_result_buffer #(
    .DEPTH       (DEPTH),
    .X_ID_WIDTH  (4),
    .X_RFW_WIDTH (32)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_id_i        (in_id_i),
    .in_rd_i        (in_rd_i),
    .in_data_i      (in_data_i),
    .in_we_i        (in_we_i),
    .in_exc_i       (in_exc_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_id_o    (result_id_o),
    .result_rd_o    (result_rd_o),
    .result_data_o  (result_data_o),
    .result_we_o    (result_we_o),
    .result_exc_o   (result_exc_o),
    .count_o        (count_o),
    .protocol_err_o (protocol_err_o)
  );

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        exc;
  } ent_t;

  // Model: in-order queue of buffered results plus per-id commit knowledge.
  ent_t m_q[$];
  bit   m_seen[NIDS];
  bit   m_kill[NIDS];
  bit   m_err;

  // Random-phase bookkeeping of in-flight instruction ids.
  bit live[NIDS];
  bit pushed[NIDS];
  bit committed[NIDS];

  int checks = 0;
  int errors = 0;

  task automatic expect_eq(string nm, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    in_valid_i     = 1'b0;
    in_id_i        = '0;
    in_rd_i        = '0;
    in_data_i      = '0;
    in_we_i        = 1'b0;
    in_exc_i       = 1'b0;
    commit_valid_i = 1'b0;
    commit_id_i    = '0;
    commit_kill_i  = 1'b0;
    result_ready_i = 1'b0;
  endtask

  task automatic set_push(int id, int rd, logic [31:0] data);
    in_valid_i = 1'b1;
    in_id_i    = 4'(id);
    in_rd_i    = 5'(rd);
    in_data_i  = data;
    in_we_i    = 1'b1;
    in_exc_i   = 1'b0;
  endtask

  task automatic set_commit(int id, bit kill);
    commit_valid_i = 1'b1;
    commit_id_i    = 4'(id);
    commit_kill_i  = kill;
  endtask

  task automatic model_clear();
    m_q.delete();
    for (int i = 0; i < NIDS; i++) begin
      m_seen[i] = 0; m_kill[i] = 0;
      live[i] = 0; pushed[i] = 0; committed[i] = 0;
    end
    m_err = 0;
  endtask

  task automatic check_outputs();
    ent_t h;
    bit   v;
    v = 0;
    h = '{default: '0};
    if (m_q.size() > 0) begin
      h = m_q[0];
      v = m_seen[h.id] && !m_kill[h.id];
    end
    expect_eq("in_ready", in_ready_o, (m_q.size() < DEPTH) ? 1 : 0);
    expect_eq("result_valid", result_valid_o, v);
    expect_eq("result_id", result_id_o, v ? h.id : 0);
    expect_eq("result_rd", result_rd_o, v ? h.rd : 0);
    expect_eq("result_data", result_data_o, v ? h.data : 0);
    expect_eq("result_we", result_we_o, v ? h.we : 0);
    expect_eq("result_exc", result_exc_o, v ? h.exc : 0);
    expect_eq("count", count_o, m_q.size());
    expect_eq("protocol_err", protocol_err_o, m_err);
  endtask

  // Apply the driven inputs over one clock edge to both DUT and model, then compare.
  task automatic step();
    ent_t h;
    bit   have, pres, drop, do_pop, do_push, pre_seen;
    have = m_q.size() > 0;
    h    = '{default: '0};
    if (have) h = m_q[0];
    pres     = have && m_seen[h.id] && !m_kill[h.id];
    drop     = have && m_seen[h.id] && m_kill[h.id];
    do_pop   = drop || (pres && result_ready_i);
    do_push  = in_valid_i && (m_q.size() < DEPTH);
    pre_seen = m_seen[commit_id_i];
    @(posedge clk_i);
    if (do_pop) begin
      m_seen[h.id] = 0;
      m_kill[h.id] = 0;
      live[h.id]   = 0;
      void'(m_q.pop_front());
    end
    if (commit_valid_i) begin
      committed[commit_id_i] = 1;
      if (pre_seen) m_err = 1;
      else begin
        m_seen[commit_id_i] = 1;
        m_kill[commit_id_i] = commit_kill_i;
      end
    end
    if (do_push) begin
      foreach (m_q[k]) if (m_q[k].id == in_id_i) m_err = 1;
      m_q.push_back('{id: in_id_i, rd: in_rd_i, data: in_data_i, we: in_we_i, exc: in_exc_i});
      pushed[in_id_i] = 1;
    end
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    set_idle();
    model_clear();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check_outputs();
  endtask

  int nlive, nid, off, j;
  bit any_live;

  initial begin
    set_idle();
    #1;
    expect_eq("rst_in_ready", in_ready_o, 0);
    expect_eq("rst_valid", result_valid_o, 0);
    expect_eq("rst_count", count_o, 0);
    expect_eq("rst_err", protocol_err_o, 0);
    @(negedge clk_i);

    // Commit before result: presented the cycle after the push, then drained.
    do_reset();
    set_commit(3, 0); step();
    set_idle(); set_push(3, 5, 32'hDEADBEEF); result_ready_i = 1; step();
    expect_eq("t1_valid", result_valid_o, 1);
    expect_eq("t1_data", result_data_o, 32'hDEADBEEF);
    expect_eq("t1_rd", result_rd_o, 5);
    set_idle(); result_ready_i = 1; step();
    expect_eq("t1_count", count_o, 0);

    // Fill with uncommitted results, push while full is refused, then commit the head.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_idle(); set_push(i, i + 1, $urandom); step();
    end
    expect_eq("t2_in_ready", in_ready_o, 0);
    expect_eq("t2_count", count_o, 4);
    expect_eq("t2_valid", result_valid_o, 0);
    set_idle(); set_push(9, 9, 32'h9); result_ready_i = 1; step();
    expect_eq("t2_full_count", count_o, 4);
    set_idle(); set_commit(0, 0); result_ready_i = 1; step();
    expect_eq("t2_head_valid", result_valid_o, 1);
    expect_eq("t2_head_id", result_id_o, 0);
    set_idle(); result_ready_i = 1; step();
    expect_eq("t2_ready_after_pop", in_ready_o, 1);
    expect_eq("t2_count_after_pop", count_o, 3);

    // Kill head 4, commit 5: 4 is dropped silently, 5 follows.
    do_reset();
    set_push(4, 4, 32'h44); step();
    set_idle(); set_push(5, 5, 32'h55); step();
    set_idle(); set_commit(4, 1); result_ready_i = 1; step();
    expect_eq("t3_drop_valid", result_valid_o, 0);
    expect_eq("t3_drop_count", count_o, 2);
    set_idle(); set_commit(5, 0); result_ready_i = 1; step();
    expect_eq("t3_id5_valid", result_valid_o, 1);
    expect_eq("t3_id5_id", result_id_o, 5);
    expect_eq("t3_id5_count", count_o, 1);
    set_idle(); result_ready_i = 1; step();

    // Backpressure: payload stays put until ready.
    do_reset();
    set_commit(6, 0); step();
    set_idle(); set_push(6, 7, 32'h12345678); step();
    repeat (3) begin
      set_idle(); step();
      expect_eq("t4_hold_valid", result_valid_o, 1);
      expect_eq("t4_hold_data", result_data_o, 32'h12345678);
      expect_eq("t4_hold_count", count_o, 1);
    end
    set_idle(); result_ready_i = 1; step();
    expect_eq("t4_popped", count_o, 0);

    // Double commit flags a sticky error; the result still leaves once.
    do_reset();
    set_commit(7, 0); step();
    set_idle(); set_commit(7, 0); step();
    expect_eq("t5_err", protocol_err_o, 1);
    set_idle(); set_push(7, 1, 32'h77); result_ready_i = 1; step();
    expect_eq("t5_valid", result_valid_o, 1);
    expect_eq("t5_id", result_id_o, 7);
    repeat (3) begin
      set_idle(); result_ready_i = 1; step();
      expect_eq("t5_gone", result_valid_o, 0);
      expect_eq("t5_err_sticky", protocol_err_o, 1);
    end

    // Asynchronous reset with committed results pending.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      set_idle(); set_commit(i, 0); step();
    end
    for (int i = 1; i <= 3; i++) begin
      set_idle(); set_push(i, i, 32'hA0 + i); step();
    end
    expect_eq("t6_pending", count_o, 3);
    #2 rst_ni = 1'b0;
    #1;
    expect_eq("t6_async_valid", result_valid_o, 0);
    expect_eq("t6_async_count", count_o, 0);
    expect_eq("t6_async_ready", in_ready_o, 0);
    model_clear();
    set_idle();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) begin
      set_idle(); result_ready_i = 1; step();
    end

    // Randomised traffic with unique live ids; commits may precede or follow results.
    do_reset();
    nid = 0;
    for (int c = 0; c < 3000; c++) begin
      set_idle();
      nlive = 0;
      for (int i = 0; i < NIDS; i++) nlive += live[i];
      if ($urandom_range(0, 3) != 0 && !live[nid] && nlive < 8) begin
        live[nid] = 1; pushed[nid] = 0; committed[nid] = 0;
        nid = (nid + 1) % NIDS;
      end
      if ($urandom_range(0, 1) == 1) begin
        off = $urandom_range(0, NIDS - 1);
        for (int k = 0; k < NIDS; k++) begin
          j = (off + k) % NIDS;
          if (live[j] && !pushed[j]) begin
            set_push(j, $urandom_range(0, 31), $urandom);
            in_we_i  = 1'($urandom_range(0, 1));
            in_exc_i = 1'($urandom_range(0, 1));
            break;
          end
        end
      end
      if ($urandom_range(0, 2) != 0) begin
        off = $urandom_range(0, NIDS - 1);
        for (int k = 0; k < NIDS; k++) begin
          j = (off + k) % NIDS;
          if (live[j] && !committed[j]) begin
            set_commit(j, $urandom_range(0, 3) == 0);
            break;
          end
        end
      end
      result_ready_i = ($urandom_range(0, 9) < 7);
      step();
    end

    // Drain everything still in flight within a bounded number of cycles.
    for (int c = 0; c < 400; c++) begin
      any_live = 0;
      for (int i = 0; i < NIDS; i++) any_live |= live[i];
      if (!any_live) break;
      set_idle();
      for (int i = 0; i < NIDS; i++)
        if (live[i] && !pushed[i]) begin set_push(i, i, $urandom); break; end
      for (int i = 0; i < NIDS; i++)
        if (live[i] && !committed[i]) begin set_commit(i, 0); break; end
      result_ready_i = 1;
      step();
    end
    any_live = 0;
    for (int i = 0; i < NIDS; i++) any_live |= live[i];
    expect_eq("drain_done", any_live, 0);
    expect_eq("drain_count", count_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
